// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for an 8-bit-PC RV32I-subset datapath.
// Latency (zero-wait acks): ALU/LUI/JAL/JALR 4, BRANCH 3, STORE 4, LOAD 5 cycles.
// Backpressure: stalls in FETCH on rom_ack (bounded by ROM_TIMEOUT) and in MEM on dmem_ack (unbounded).
module fetch_exec_sequencer #(
    parameter int CNT_W       = 16,
    parameter int ROM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             rom_ack,
    input  logic             br_taken,
    input  logic             dmem_ack,
    output logic             rom_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic             alu_src_imm,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILL = 4'd0, C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_SYS
    } cls_t;

    localparam int TW = $clog2(ROM_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(ROM_TIMEOUT - 1);

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b1110011: return C_SYS;
            default:    return C_ILL;
        endcase
    endfunction

    state_t          state, nxt;
    cls_t            cls;
    logic [TW-1:0]   tcnt;
    logic            cls_ld, tcnt_clr, tcnt_inc, err_set, retire;
    logic            unused_instr;

    // Only the opcode field steers sequencing; the rest belongs to the datapath.
    assign unused_instr = ^instr[31:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls     <= C_ILL;
            tcnt    <= '0;
            err     <= 1'b0;
            retired <= '0;
        end else begin
            if (cls_ld)        cls  <= classify(instr[6:0]);
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt + 1'b1;
            if (err_set)       err  <= 1'b1;
            if (retire)        retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nxt         = state;
        rom_req     = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 2'b00;
        rf_we       = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        cls_ld      = 1'b0;
        tcnt_clr    = 1'b0;
        tcnt_inc    = 1'b0;
        err_set     = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: if (start) nxt = S_FETCH;
            S_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    ir_load  = 1'b1;
                    cls_ld   = 1'b1;
                    tcnt_clr = 1'b1;
                    nxt      = S_DECODE;
                end else if (tcnt == TLIM) begin
                    err_set = 1'b1;
                    nxt     = S_HALT;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (cls == C_SYS) begin
                    nxt = S_HALT;
                end else if (cls == C_ILL) begin
                    err_set = 1'b1;
                    nxt     = S_HALT;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls == C_LOAD || cls == C_STORE) begin
                    nxt = S_MEM;
                end else if (cls == C_BR) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken ? 2'b01 : 2'b00;
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_rd = (cls == C_LOAD);
                mem_wr = (cls != C_LOAD);
                if (dmem_ack) begin
                    if (cls == C_LOAD) begin
                        nxt = S_WB;
                    end else begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_en  = 1'b1;
                pc_sel = (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
                retire = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    assign alu_src_imm = (state == S_EXEC || state == S_MEM || state == S_WB) &&
                         (cls == C_I || cls == C_LOAD || cls == C_STORE ||
                          cls == C_JALR || cls == C_LUI);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule
